flash_reader: RTL and testbench

FLASH_READER -- requirements
Module: flash_reader

---
 rtl/flash_reader.sv | 175 +++++++++++++++++
 tb/tb_flash_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_reader.sv
`timescale 1ns/1ps
// flash_reader: Wishbone master toward an SPI master that issues a flash READ (0x03),
// a 24-bit address, then streams the returned bytes out on a valid/ready port.
module flash_reader (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [7:0]  DAT_O,
  input  logic [7:0]  DAT_I,
  input  logic        ACK_I,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  // state | meaning
  // IDLE  | waiting for start
  // CMD   | writing read opcode 0x03
  // A2    | writing addr[23:16]
  // A1    | writing addr[15:8]
  // A0    | writing addr[7:0]
  // READ  | strobing a dummy byte to clock in one data byte
  // HOLD  | presenting the byte on the stream until taken
  // FIN   | done pulse, chip-select released
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_A2   = 3'd2,
    S_A1   = 3'd3,
    S_A0   = 3'd4,
    S_READ = 3'd5,
    S_HOLD = 3'd6,
    S_FIN  = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_addr;
  logic [15:0] r_remain;
  logic [7:0]  r_wdog;
  logic [7:0]  r_out_data;
  logic        r_err;

  logic        w_cyc;
  logic        w_stb;
  logic        w_we;
  logic [7:0]  w_dat;
  logic        w_ack;
  logic        w_timeout;

  // ACK_I only counts while strobing; the watchdog aborts on the edge it would hit 255
  assign w_ack     = w_stb & ACK_I;
  assign w_timeout = w_stb & ~ACK_I & (r_wdog == 8'hFE);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (len == 16'd0) ? S_FIN : S_CMD;
        end
      end
      S_CMD: begin
        if (w_timeout)  w_next = S_IDLE;
        else if (w_ack) w_next = S_A2;
      end
      S_A2: begin
        if (w_timeout)  w_next = S_IDLE;
        else if (w_ack) w_next = S_A1;
      end
      S_A1: begin
        if (w_timeout)  w_next = S_IDLE;
        else if (w_ack) w_next = S_A0;
      end
      S_A0: begin
        if (w_timeout)  w_next = S_IDLE;
        else if (w_ack) w_next = S_READ;
      end
      S_READ: begin
        if (w_timeout)  w_next = S_IDLE;
        else if (w_ack) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          w_next = (r_remain != 16'd0) ? S_READ : S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cyc = 1'b0;
    w_stb = 1'b0;
    w_we  = 1'b0;
    w_dat = 8'h00;
    case (r_state)
      S_CMD: begin
        w_cyc = 1'b1; w_stb = 1'b1; w_we = 1'b1; w_dat = 8'h03;
      end
      S_A2: begin
        w_cyc = 1'b1; w_stb = 1'b1; w_we = 1'b1; w_dat = r_addr[23:16];
      end
      S_A1: begin
        w_cyc = 1'b1; w_stb = 1'b1; w_we = 1'b1; w_dat = r_addr[15:8];
      end
      S_A0: begin
        w_cyc = 1'b1; w_stb = 1'b1; w_we = 1'b1; w_dat = r_addr[7:0];
      end
      S_READ: begin
        w_cyc = 1'b1; w_stb = 1'b1;
      end
      S_HOLD: begin
        w_cyc = 1'b1;
      end
      default: begin
        w_cyc = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_addr     <= 24'd0;
      r_remain   <= 16'd0;
      r_wdog     <= 8'd0;
      r_out_data <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (r_state == S_IDLE && start && len != 16'd0) begin
        r_addr   <= addr;
        r_remain <= len;
      end
      if (r_state == S_READ && w_ack) begin
        r_out_data <= DAT_I;
        r_remain   <= r_remain - 16'd1;
      end
      // strobe low covers both the clear-on-assert and the idle cases
      if (!w_stb || ACK_I) begin
        r_wdog <= 8'd0;
      end else begin
        r_wdog <= r_wdog + 8'd1;
      end
    end
  end

  assign CYC_O     = w_cyc;
  assign STB_O     = w_stb;
  assign WE_O      = w_we;
  assign DAT_O     = w_dat;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign err       = r_err;
  assign out_valid = (r_state == S_HOLD);
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_flash_reader.sv
`timescale 1ns/1ps
// Bench for flash_reader: a Wishbone slave and stream sink with random latency and
// backpressure, checked against the expected command bytes and returned data.
module tb_flash_reader;
  typedef logic [7:0] bq_t[$];

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        start = 1'b0;
  logic [23:0] addr  = 24'd0;
  logic [15:0] len   = 16'd0;
  logic        busy, done, err, CYC_O, STB_O, WE_O;
  logic [7:0]  DAT_O;
  logic [7:0]  DAT_I = 8'd0;
  logic        ACK_I = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  flash_reader dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .DAT_O(DAT_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLK_I = ~CLK_I;

  int n_cmp = 0;
  int n_bad = 0;

  // driven by the test tasks only
  bit         slave_en = 1'b1;
  int         lat_min = 1, lat_max = 1;
  int         rdy_mode = 0;
  logic       man_ready = 1'b0;
  logic [7:0] pre_bytes[4];
  int         n_pre = 0;
  int         clr_seq = 0;

  // driven by the slave/monitor process only
  int         clr_seen = 0;
  int         wcnt = 0, lat_cur = 1, pre_idx = 0;
  logic       rand_ready = 1'b1;
  logic       rdy_now;
  bq_t        wr_q, ret_q, got_q;
  int         rd_cnt, rd_dat_bad, cyc_rises, done_cyc, err_cyc, stb_cyc, ov_cyc, wr_gap, hold_viol;
  logic       prev_cyc = 1'b0, prev_ov = 1'b0;
  logic [7:0] prev_od = 8'd0;

  assign out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? rand_ready : man_ready;

  always @(negedge CLK_I) begin
    if (clr_seq != clr_seen) begin
      clr_seen = clr_seq;
      wr_q.delete(); ret_q.delete(); got_q.delete();
      rd_cnt = 0; rd_dat_bad = 0; cyc_rises = 0; done_cyc = 0; err_cyc = 0;
      stb_cyc = 0; ov_cyc = 0; wr_gap = 0; hold_viol = 0; pre_idx = 0;
      lat_cur = $urandom_range(lat_max, lat_min);
    end
    if (!RST_I) begin
      ACK_I = 1'b0;
      wcnt  = 0;
    end else begin
      if (ACK_I) begin
        ACK_I   = 1'b0;
        wcnt    = 0;
        lat_cur = $urandom_range(lat_max, lat_min);
      end
      if (slave_en && STB_O) begin
        if (wcnt >= lat_cur) begin
          ACK_I = 1'b1;
          if (WE_O) begin
            wr_q.push_back(DAT_O);
            DAT_I = 8'($urandom);
          end else begin
            rd_cnt++;
            if (DAT_O !== 8'h00) rd_dat_bad++;
            if (pre_idx < n_pre) begin
              DAT_I = pre_bytes[pre_idx];
              pre_idx++;
            end else begin
              DAT_I = 8'($urandom);
            end
            ret_q.push_back(DAT_I);
          end
        end else begin
          wcnt++;
        end
      end
    end
    rand_ready = ($urandom_range(0, 3) != 0);
    rdy_now = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? rand_ready : man_ready;
    if (CYC_O && !prev_cyc) cyc_rises++;
    if (done) done_cyc++;
    if (err) err_cyc++;
    if (STB_O) stb_cyc++;
    if (out_valid) ov_cyc++;
    if (CYC_O && WE_O && !STB_O) wr_gap++;
    if (prev_ov && out_valid && out_data !== prev_od) hold_viol++;
    if (out_valid && rdy_now) got_q.push_back(out_data);
    prev_cyc = CYC_O;
    prev_ov  = out_valid;
    prev_od  = out_data;
  end

  function automatic int q_diff(input bq_t a, input bq_t b);
    int d = 0;
    if (a.size() != b.size()) return -1;
    foreach (a[i]) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  task automatic clear_logs();
    clr_seq++;
    @(negedge CLK_I);
    #1;
  endtask

  task automatic run_xfer(input logic [23:0] a, input logic [15:0] l, input int budget, output bit ok);
    int cnt = 0;
    @(posedge CLK_I); #1;
    addr = a; len = l; start = 1'b1;
    @(posedge CLK_I); #1;
    start = 1'b0;
    while (!(done === 1'b1 || err === 1'b1) && cnt < budget) begin
      @(posedge CLK_I); #1;
      cnt++;
    end
    ok = (done === 1'b1 || err === 1'b1);
    repeat (2) @(posedge CLK_I);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] v;
    RST_I = 1'b0; start = 1'b0;
    #3;
    v = {busy, done, err, CYC_O, STB_O, WE_O, DAT_O, out_data, out_valid};
    n_cmp++;
    if (v !== 23'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", v); end
    @(posedge CLK_I); #1;
    RST_I = 1'b1;
    clear_logs();
    repeat (10) @(posedge CLK_I);
    #1;
    n_cmp++;
    if (cyc_rises !== 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_cyc: cyc_rises=%0d busy=%b want 0/0", cyc_rises, busy);
    end
  endtask

  task automatic test_normal();
    bit  ok;
    bq_t exp_wr, exp_rd;
    slave_en = 1'b1; lat_min = 1; lat_max = 1; rdy_mode = 0;
    pre_bytes[0] = 8'hA5; pre_bytes[1] = 8'h5A; n_pre = 2;
    clear_logs();
    run_xfer(24'h123456, 16'd2, 200, ok);
    exp_wr.push_back(8'h03); exp_wr.push_back(8'h12); exp_wr.push_back(8'h34); exp_wr.push_back(8'h56);
    exp_rd.push_back(8'hA5); exp_rd.push_back(8'h5A);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL normal_timeout: no done/err within budget"); end
    n_cmp++; if (q_diff(wr_q, exp_wr) != 0) begin n_bad++; $display("FAIL normal_cmd_bytes: got %0d bytes diff=%0d want 03 12 34 56", wr_q.size(), q_diff(wr_q, exp_wr)); end
    n_cmp++; if (rd_cnt != 2 || rd_dat_bad != 0) begin n_bad++; $display("FAIL normal_reads: got %0d reads (%0d bad DAT_O) want 2 (0)", rd_cnt, rd_dat_bad); end
    n_cmp++; if (q_diff(got_q, exp_rd) != 0) begin n_bad++; $display("FAIL normal_stream: got %0d bytes diff=%0d want A5 5A", got_q.size(), q_diff(got_q, exp_rd)); end
    n_cmp++; if (cyc_rises != 1 || wr_gap != 0) begin n_bad++; $display("FAIL normal_cyc: cyc_rises=%0d wr_gap=%0d want 1/0", cyc_rises, wr_gap); end
    n_cmp++; if (done_cyc != 1 || err_cyc != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL normal_done: done_cyc=%0d err_cyc=%0d busy=%b want 1/0/0", done_cyc, err_cyc, busy); end
  endtask

  task automatic test_backpressure();
    int  cnt = 0;
    int  bad = 0;
    bq_t exp_rd;
    slave_en = 1'b1; lat_min = 1; lat_max = 1; rdy_mode = 2; man_ready = 1'b0;
    pre_bytes[0] = 8'hA5; pre_bytes[1] = 8'h5A; n_pre = 2;
    clear_logs();
    @(posedge CLK_I); #1;
    addr = 24'h00ABCD; len = 16'd2; start = 1'b1;
    @(posedge CLK_I); #1;
    start = 1'b0;
    while (out_valid !== 1'b1 && cnt < 100) begin @(posedge CLK_I); #1; cnt++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_first_byte: out_valid=%b want 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK_I); #1;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || STB_O !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_hold: %0d cycles off, last out_valid=%b out_data=%h STB_O=%b want 1/a5/0", bad, out_valid, out_data, STB_O); end
    man_ready = 1'b1;
    @(posedge CLK_I); #1;
    n_cmp++; if (out_valid !== 1'b0 || STB_O !== 1'b1) begin n_bad++; $display("FAIL bp_next_read: out_valid=%b STB_O=%b want 0/1", out_valid, STB_O); end
    cnt = 0;
    while (done !== 1'b1 && cnt < 100) begin @(posedge CLK_I); #1; cnt++; end
    repeat (2) @(posedge CLK_I);
    #1;
    exp_rd.push_back(8'hA5); exp_rd.push_back(8'h5A);
    n_cmp++; if (q_diff(got_q, exp_rd) != 0 || done_cyc != 1) begin n_bad++; $display("FAIL bp_stream: got %0d bytes diff=%0d done_cyc=%0d want A5 5A, 1", got_q.size(), q_diff(got_q, exp_rd), done_cyc); end
    rdy_mode = 0;
  endtask

  task automatic test_len_zero();
    clear_logs();
    @(posedge CLK_I); #1;
    addr = 24'($urandom); len = 16'd0; start = 1'b1;
    @(posedge CLK_I); #1;
    start = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL len0_done: done=%b want 1", done); end
    @(posedge CLK_I); #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL len0_after: done=%b busy=%b want 0/0", done, busy); end
    repeat (3) @(posedge CLK_I);
    #1;
    n_cmp++; if (cyc_rises != 0 || stb_cyc != 0 || ov_cyc != 0 || done_cyc != 1) begin
      n_bad++; $display("FAIL len0_quiet: cyc=%0d stb=%0d ov=%0d done=%0d want 0/0/0/1", cyc_rises, stb_cyc, ov_cyc, done_cyc);
    end
  endtask

  task automatic test_watchdog();
    int cnt = 0;
    slave_en = 1'b0; rdy_mode = 0;
    clear_logs();
    @(posedge CLK_I); #1;
    addr = 24'h0F0F0F; len = 16'd3; start = 1'b1;
    @(posedge CLK_I); #1;
    start = 1'b0;
    while (!(err === 1'b1 || done === 1'b1) && cnt < 400) begin @(posedge CLK_I); #1; cnt++; end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL wd_err: err=%b after %0d cycles want 1", err, cnt); end
    n_cmp++; if (CYC_O !== 1'b0 || STB_O !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL wd_abort: CYC_O=%b STB_O=%b busy=%b out_valid=%b want 0", CYC_O, STB_O, busy, out_valid);
    end
    @(posedge CLK_I); #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wd_pulse: err=%b want 0", err); end
    repeat (3) @(posedge CLK_I);
    #1;
    n_cmp++; if (stb_cyc != 255 || err_cyc != 1 || done_cyc != 0) begin
      n_bad++; $display("FAIL wd_count: stb_cycles=%0d err_cyc=%0d done_cyc=%0d want 255/1/0", stb_cyc, err_cyc, done_cyc);
    end
    slave_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int          cnt = 0;
    bit          ok;
    logic [22:0] v;
    logic [23:0] a;
    bq_t         exp_wr;
    slave_en = 1'b1; lat_min = 0; lat_max = 2; rdy_mode = 2; man_ready = 1'b0; n_pre = 0;
    clear_logs();
    @(posedge CLK_I); #1;
    addr = 24'($urandom); len = 16'd4; start = 1'b1;
    @(posedge CLK_I); #1;
    start = 1'b0;
    while (out_valid !== 1'b1 && cnt < 100) begin @(posedge CLK_I); #1; cnt++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_mid_valid: out_valid=%b want 1", out_valid); end
    @(posedge CLK_I);
    #3;
    RST_I = 1'b0;
    #1;
    v = {busy, done, err, CYC_O, STB_O, WE_O, DAT_O, out_data, out_valid};
    n_cmp++; if (v !== 23'd0) begin n_bad++; $display("FAIL rst_mid_outputs: got %h want 0", v); end
    @(posedge CLK_I); #1;
    RST_I = 1'b1;
    rdy_mode = 0;
    clear_logs();
    a = 24'($urandom);
    run_xfer(a, 16'd1, 100, ok);
    exp_wr.push_back(8'h03); exp_wr.push_back(a[23:16]); exp_wr.push_back(a[15:8]); exp_wr.push_back(a[7:0]);
    n_cmp++; if (!ok || done_cyc != 1 || err_cyc != 0) begin n_bad++; $display("FAIL rst_mid_rerun: ok=%0d done_cyc=%0d err_cyc=%0d want 1/1/0", ok, done_cyc, err_cyc); end
    n_cmp++; if (q_diff(wr_q, exp_wr) != 0 || rd_cnt != 1 || q_diff(got_q, ret_q) != 0 || got_q.size() != 1) begin
      n_bad++; $display("FAIL rst_mid_data: wr_diff=%0d reads=%0d got=%0d want 0/1/1", q_diff(wr_q, exp_wr), rd_cnt, got_q.size());
    end
  endtask

  task automatic test_random();
    bit          ok;
    logic [23:0] a;
    int          l;
    bq_t         exp_wr;
    slave_en = 1'b1; lat_min = 0; lat_max = 3; rdy_mode = 1; n_pre = 0;
    for (int it = 0; it < 6; it++) begin
      a = 24'($urandom);
      l = $urandom_range(1, 8);
      clear_logs();
      run_xfer(a, 16'(l), 400, ok);
      exp_wr.delete();
      exp_wr.push_back(8'h03); exp_wr.push_back(a[23:16]); exp_wr.push_back(a[15:8]); exp_wr.push_back(a[7:0]);
      n_cmp++; if (!ok || done_cyc != 1 || err_cyc != 0) begin n_bad++; $display("FAIL rand%0d_done: ok=%0d done_cyc=%0d err_cyc=%0d want 1/1/0", it, ok, done_cyc, err_cyc); end
      n_cmp++; if (q_diff(wr_q, exp_wr) != 0 || wr_gap != 0) begin n_bad++; $display("FAIL rand%0d_cmd: diff=%0d wr_gap=%0d addr=%h want 0/0", it, q_diff(wr_q, exp_wr), wr_gap, a); end
      n_cmp++; if (rd_cnt != l || got_q.size() != l || q_diff(got_q, ret_q) != 0) begin
        n_bad++; $display("FAIL rand%0d_stream: reads=%0d got=%0d diff=%0d want %0d bytes matching", it, rd_cnt, got_q.size(), q_diff(got_q, ret_q), l);
      end
      n_cmp++; if (cyc_rises != 1 || hold_viol != 0 || rd_dat_bad != 0) begin
        n_bad++; $display("FAIL rand%0d_framing: cyc_rises=%0d hold_viol=%0d rd_dat_bad=%0d want 1/0/0", it, cyc_rises, hold_viol, rd_dat_bad);
      end
    end
    rdy_mode = 0;
  endtask

  task automatic test_back_to_back();
    int          cnt = 0;
    bit          ok;
    logic [23:0] a;
    bq_t         exp_wr;
    slave_en = 1'b1; lat_min = 1; lat_max = 1; rdy_mode = 0; n_pre = 0;
    a = 24'hC0FFEE;
    clear_logs();
    @(posedge CLK_I); #1;
    addr = a; len = 16'd3; start = 1'b1;
    @(posedge CLK_I); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK_I);
    #1;
    addr = 24'h111111; len = 16'd7; start = 1'b1;
    @(posedge CLK_I); #1;
    start = 1'b0;
    while (done !== 1'b1 && cnt < 200) begin @(posedge CLK_I); #1; cnt++; end
    repeat (2) @(posedge CLK_I);
    #1;
    exp_wr.push_back(8'h03); exp_wr.push_back(a[23:16]); exp_wr.push_back(a[15:8]); exp_wr.push_back(a[7:0]);
    n_cmp++; if (rd_cnt != 3 || cyc_rises != 1 || done_cyc != 1 || q_diff(wr_q, exp_wr) != 0) begin
      n_bad++; $display("FAIL busy_start_ignored: reads=%0d cyc_rises=%0d done_cyc=%0d wr_diff=%0d want 3/1/1/0", rd_cnt, cyc_rises, done_cyc, q_diff(wr_q, exp_wr));
    end
    clear_logs();
    run_xfer(24'h000001, 16'd2, 200, ok);
    n_cmp++; if (!ok || rd_cnt != 2 || q_diff(got_q, ret_q) != 0 || done_cyc != 1) begin
      n_bad++; $display("FAIL back_to_back: ok=%0d reads=%0d stream_diff=%0d done_cyc=%0d want 1/2/0/1", ok, rd_cnt, q_diff(got_q, ret_q), done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_len_zero();
    test_watchdog();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got %0d compared want completion", n_cmp);
    $fatal(1);
  end

endmodule
